// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver (8N1, optional 8E1) feeding a byte FIFO with RTS flow control
//
// Parameters: CLK_HZ (clock Hz), BAUD (bit/s), DEPTH (FIFO entries, power of two, 4..256),
//             RTS_THRESH (fill level at or above which rts asserts).
// Optional macro: UART_RX_PARITY_EN -- selects 8E1 framing with a PARITY state before STOP.
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial line, idle high
//   rts        out  1 = sender must pause (registered from fill level)
//   dout       out  FIFO head byte (registered)
//   valid      out  dout holds a byte
//   ready      in   consumer accepts dout; pop on valid && ready
//   frame_err  out  one-cycle pulse: bad stop bit (or bad parity in 8E1)
//   overrun    out  one-cycle pulse: received byte dropped, FIFO full
module uart_rx_fifo #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH      = 16,
    parameter int RTS_THRESH = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rts,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW      = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Receiver state
    logic          rx_s1, rx_s2, rx_prev;
    logic          fall;
    logic [DW-1:0] div_cnt;
    logic          tick;
    state_t        state, state_n;
    logic [3:0]    tick_cnt, tick_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift, shift_n;
    logic          err_hold, err_hold_n;
    logic          par_bad, par_bad_n;
    logic          restart, push_req, ferr;

    // FIFO state
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [AW:0]   count, count_n;
    logic          pop, push_ok;

    assign fall = rx_prev && !rx_s2;
    assign tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            div_cnt   <= '0;
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            err_hold  <= 1'b0;
            par_bad   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            // Restarting on the start edge centres every later sample in its bit cell.
            div_cnt   <= (restart || tick) ? '0 : div_cnt + DW'(1);
            state     <= state_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            shift     <= shift_n;
            err_hold  <= err_hold_n;
            par_bad   <= par_bad_n;
            frame_err <= ferr;
            overrun   <= push_req && !push_ok;
        end
    end

    always_comb begin
        state_n    = state;
        tick_n     = tick_cnt;
        bit_n      = bit_cnt;
        shift_n    = shift;
        err_hold_n = err_hold;
        par_bad_n  = par_bad;
        restart    = 1'b0;
        push_req   = 1'b0;
        ferr       = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_n = S_START;
                    tick_n  = '0;
                    restart = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd7) begin
                        // Mid start bit: still low means a real frame, high is a glitch.
                        tick_n    = '0;
                        bit_n     = '0;
                        par_bad_n = 1'b0;
                        state_n   = rx_s2 ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shift_n = {rx_s2, shift[7:1]};
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = S_PARITY;
`else
                            state_n = S_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        // Even parity: data bits plus parity bit hold an even number of ones.
                        par_bad_n = (rx_s2 != ^shift);
                        state_n   = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (err_hold) begin
                    // Line was low at the stop sample; wait for idle before hunting a new start.
                    if (rx_s2) begin
                        err_hold_n = 1'b0;
                        state_n    = S_IDLE;
                    end
                end else if (tick) begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        if (rx_s2) begin
                            state_n = S_IDLE;
                            if (par_bad) ferr = 1'b1;
                            else         push_req = 1'b1;
                        end else begin
                            ferr       = 1'b1;
                            err_hold_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FIFO: a full FIFO still accepts a byte when the head leaves in the same clock.
    assign pop     = valid && ready;
    assign push_ok = push_req && ((count < (AW + 1)'(DEPTH)) || pop);

    always_comb begin
        rd_ptr_n = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_n  = count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            dout   <= '0;
            rts    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            valid  <= (count_n != '0);
            // The next head is the incoming byte only when it lands at the new read slot.
            if (push_ok && (wr_ptr == rd_ptr_n)) dout <= shift;
            else if (count_n != '0)              dout <= mem[rd_ptr_n];
            rts    <= (count >= (AW + 1)'(RTS_THRESH));
        end
    end

endmodule
